// File: rtl/os_array_feeder_pkg.sv
// os_array_pkg: shared constants and types for the output-stationary array feeder.
//   N_DEF / W_DEF : default array dimension and element width
//   FLUSH_LEN     : number of drain cycles after the last vector for the default N
//   feeder_state_t: feeder control FSM state encoding
//   flush_len()   : drain length 2N-1 for an arbitrary array dimension
package os_array_pkg;

    localparam int N_DEF     = 4;
    localparam int W_DEF     = 32;
    localparam int FLUSH_LEN = 2 * N_DEF - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

    // The last operand reaches PE(N-1,N-1) after (N-1)+(N-1) skew/hop cycles,
    // plus one cycle for that final MAC to land in the accumulator.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/os_array_feeder_if.sv
// os_array_feeder_if: operand stream from a producer into the feeder.
//   in_valid : in_a/in_b/in_last valid this cycle
//   in_ready : feeder accepts a vector this cycle
//   in_last  : final vector of the job
//   in_a     : A column, lane i at [i*W +: W]
//   in_b     : B row, lane i at [i*W +: W]
// modport master = producer side, modport slave = feeder side.
interface os_array_feeder_if
    import os_array_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [N*W-1:0]   in_a;
    logic [N*W-1:0]   in_b;

    modport master (
        output in_valid,
        output in_last,
        output in_a,
        output in_b,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_last,
        input  in_a,
        input  in_b,
        output in_ready
    );

endinterface

// File: rtl/os_array_feeder_skew_line.sv
// os_skew_line: one lane's delay line of DEPTH registers.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous flush of every stage to zero
//   din      : element entering the line (zero for bubbles)
//   dout     : element leaving the line, DEPTH cycles after din
module os_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_r [DEPTH];

    // Shift register: stage 0 takes din, every other stage takes its predecessor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            stage_r[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/os_array_feeder.sv
// os_array_feeder: accepts A-column / B-row vectors and skews them into the
// edge PEs of an N x N output-stationary systolic array, sequencing the
// accumulator clear, streaming, drain and completion of one job.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : begin a job (only honoured in IDLE)
//   in_if          : operand stream (slave side)
//   arr_a / arr_b  : skewed operands, lane i delayed i+1 cycles after accept
//   arr_rstn_pipe  : active-low operand-pipe clear to the array
//   arr_rstn_psum  : active-low accumulator clear to the array
//   busy           : feeder not idle
//   done           : one-cycle pulse once every accumulator holds its result
module os_array_feeder
    import os_array_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    os_array_feeder_if.slave    in_if,
    output logic [N*W-1:0]      arr_a,
    output logic [N*W-1:0]      arr_b,
    output logic                arr_rstn_pipe,
    output logic                arr_rstn_psum,
    output logic                busy,
    output logic                done
);

    localparam int              CNT_W      = $clog2(2 * N);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(flush_len(N));

    feeder_state_t    state_r;
    feeder_state_t    state_s;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] flush_cnt_s;
    logic             rstn_r;
    logic             accept_s;
    logic             clear_s;
    logic [N*W-1:0]   lane_a_s;
    logic [N*W-1:0]   lane_b_s;

    assign accept_s = (state_r == ST_STREAM) && in_if.in_valid;

    // Next-state and flush-counter logic.
    always_comb begin
        state_s     = state_r;
        flush_cnt_s = flush_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (accept_s && in_if.in_last) begin
                    state_s     = ST_FLUSH;
                    flush_cnt_s = FLUSH_LOAD;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == CNT_W'(1)) begin
                    state_s     = ST_DONE;
                    flush_cnt_s = '0;
                end else begin
                    flush_cnt_s = flush_cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s     = ST_IDLE;
                flush_cnt_s = '0;
            end
        endcase
    end

    // State, flush counter and array-clear registers. The clear is computed
    // from the next state so it is low for exactly the CLEAR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= '0;
            rstn_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            flush_cnt_r <= flush_cnt_s;
            rstn_r      <= (state_s != ST_CLEAR);
        end
    end

    assign arr_rstn_pipe = rstn_r;
    assign arr_rstn_psum = rstn_r;
    assign in_if.in_ready = (state_r == ST_STREAM);
    assign busy           = (state_r != ST_IDLE);
    assign done           = (state_r == ST_DONE);

    // Bubbles and every non-accepted cycle feed zeros so the MACs see 0.
    assign lane_a_s = accept_s ? in_if.in_a : '0;
    assign lane_b_s = accept_s ? in_if.in_b : '0;
    assign clear_s  = (state_s == ST_CLEAR);

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        os_skew_line #(
            .DEPTH (gi + 1),
            .W     (W)
        ) u_skew_a (
            .clk   (clk),
            .rst   (rst),
            .clear (clear_s),
            .din   (lane_a_s[gi*W +: W]),
            .dout  (arr_a[gi*W +: W])
        );

        os_skew_line #(
            .DEPTH (gi + 1),
            .W     (W)
        ) u_skew_b (
            .clk   (clk),
            .rst   (rst),
            .clear (clear_s),
            .din   (lane_b_s[gi*W +: W]),
            .dout  (arr_b[gi*W +: W])
        );
    end

endmodule
